// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: reference cosine table, data widths, symbol encodings
// and bit-to-sign mapping, used by both the symbol generator and the detector.
package qpsk_pkg;

  localparam int SPS    = 16;
  localparam int DATA_W = 10;
  localparam int ACC_W  = 24;
  localparam int REF_W  = 9;

  typedef logic signed [REF_W-1:0] ref_t;

  // Symbol naming is {b1,b0}: b1 selects the cosine sign, b0 the sine sign.
  typedef enum logic [1:0] {
    SYM_00 = 2'b00,
    SYM_01 = 2'b01,
    SYM_10 = 2'b10,
    SYM_11 = 2'b11
  } qpsk_sym_t;

  function automatic ref_t cos_ref(input logic [3:0] k);
    ref_t r;
    case (k)
      4'd0:    r = 9'sd100;
      4'd1:    r = 9'sd92;
      4'd2:    r = 9'sd71;
      4'd3:    r = 9'sd38;
      4'd4:    r = 9'sd0;
      4'd5:    r = -9'sd38;
      4'd6:    r = -9'sd71;
      4'd7:    r = -9'sd92;
      4'd8:    r = -9'sd100;
      4'd9:    r = -9'sd92;
      4'd10:   r = -9'sd71;
      4'd11:   r = -9'sd38;
      4'd12:   r = 9'sd0;
      4'd13:   r = 9'sd38;
      4'd14:   r = 9'sd71;
      default: r = 9'sd92;
    endcase
    return r;
  endfunction

  // A set bit transmits the reference with positive sign.
  function automatic logic signed [1:0] bit_to_sign(input logic b);
    return b ? 2'sd1 : -2'sd1;
  endfunction

endpackage

// File: rtl/qpsk_ref_rom.sv
// Combinational cosine/sine reference lookup for one 16-phase symbol period.
module qpsk_ref_rom
  import qpsk_pkg::*;
(
  input  logic [3:0] phase,
  output ref_t       cos_o,
  output ref_t       sin_o
);

  logic [3:0] sin_idx;

  // Sine is the cosine table delayed by a quarter period (4 phases).
  always_comb begin
    sin_idx = phase + 4'd12;
    cos_o   = cos_ref(phase);
    sin_o   = cos_ref(sin_idx);
  end

endmodule

// File: rtl/qpsk_symbol_detector.sv
// Correlating QPSK detector: multiplies each sample by cos/sin references,
// integrates over a 16-sample symbol and decides bits from the correlation signs.
module qpsk_symbol_detector
  import qpsk_pkg::*;
#(
  parameter int DATA_W   = qpsk_pkg::DATA_W,
  parameter int ACC_W    = qpsk_pkg::ACC_W,
  parameter int E_THRESH = 40000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     sync_clr,
  output logic [1:0]               sym_bits,
  output logic                     sym_valid,
  output logic signed [ACC_W-1:0]  i_acc,
  output logic signed [ACC_W-1:0]  q_acc,
  output logic                     sym_err,
  output logic [15:0]              sym_count
);

  localparam int PROD_W = DATA_W + REF_W;

  // Input handshake: sample_in is consumed on every rising edge where
  // sample_valid=1 and sync_clr=0; there is no ready, the block never stalls.
  logic                     accept;
  logic [3:0]               phase_q, phase_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q, s1_last_d;
  logic signed [PROD_W-1:0] pi_q, pi_d, pq_q, pq_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic                     fin_valid_q, fin_valid_d;
  logic signed [ACC_W-1:0]  fin_i_q, fin_i_d, fin_q_q, fin_q_d;
  logic [1:0]               sym_bits_q, sym_bits_d;
  logic                     sym_valid_q, sym_valid_d;
  logic signed [ACC_W-1:0]  i_acc_q, i_acc_d, q_acc_q, q_acc_d;
  logic                     sym_err_q, sym_err_d;
  logic [15:0]              sym_count_q, sym_count_d;

  ref_t                     cos_w, sin_w;
  logic signed [ACC_W-1:0]  sum_i, sum_q;
  logic [ACC_W-1:0]         abs_i, abs_q;
  logic [ACC_W:0]           energy;

  qpsk_ref_rom u_rom (
    .phase (phase_q),
    .cos_o (cos_w),
    .sin_o (sin_w)
  );

  always_comb begin
    accept      = sample_valid && !sync_clr;
    phase_d     = phase_q;
    s1_valid_d  = accept;
    s1_last_d   = s1_last_q;
    pi_d        = pi_q;
    pq_d        = pq_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    fin_valid_d = 1'b0;
    fin_i_d     = fin_i_q;
    fin_q_d     = fin_q_q;
    sum_i       = acc_i_q + ACC_W'(pi_q);
    sum_q       = acc_q_q + ACC_W'(pq_q);

    if (sync_clr) begin
      phase_d = 4'd0;
    end else if (accept) begin
      phase_d   = phase_q + 4'd1;
      pi_d      = PROD_W'(sample_in) * PROD_W'(cos_w);
      pq_d      = PROD_W'(sample_in) * PROD_W'(sin_w);
      s1_last_d = (phase_q == 4'(SPS - 1));
    end

    // The closing sample's sum goes straight to the final registers while the
    // accumulators restart, so a following symbol can begin on the next edge.
    if (sync_clr) begin
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (s1_valid_q) begin
      if (s1_last_q) begin
        fin_valid_d = 1'b1;
        fin_i_d     = sum_i;
        fin_q_d     = sum_q;
        acc_i_d     = '0;
        acc_q_d     = '0;
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
      end
    end
  end

  always_comb begin
    abs_i       = fin_i_q[ACC_W-1] ? ACC_W'(-fin_i_q) : fin_i_q;
    abs_q       = fin_q_q[ACC_W-1] ? ACC_W'(-fin_q_q) : fin_q_q;
    energy      = {1'b0, abs_i} + {1'b0, abs_q};
    sym_valid_d = 1'b0;
    sym_bits_d  = sym_bits_q;
    i_acc_d     = i_acc_q;
    q_acc_d     = q_acc_q;
    sym_err_d   = sym_err_q;
    sym_count_d = sym_count_q;
    if (fin_valid_q && !sync_clr) begin
      sym_valid_d = 1'b1;
      sym_bits_d  = {~fin_i_q[ACC_W-1], ~fin_q_q[ACC_W-1]};
      i_acc_d     = fin_i_q;
      q_acc_d     = fin_q_q;
      sym_err_d   = (energy < (ACC_W+1)'(E_THRESH));
      sym_count_d = sym_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      pi_q        <= '0;
      pq_q        <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      fin_valid_q <= 1'b0;
      fin_i_q     <= '0;
      fin_q_q     <= '0;
      sym_bits_q  <= '0;
      sym_valid_q <= 1'b0;
      i_acc_q     <= '0;
      q_acc_q     <= '0;
      sym_err_q   <= 1'b0;
      sym_count_q <= '0;
    end else begin
      phase_q     <= phase_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      pi_q        <= pi_d;
      pq_q        <= pq_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      fin_valid_q <= fin_valid_d;
      fin_i_q     <= fin_i_d;
      fin_q_q     <= fin_q_d;
      sym_bits_q  <= sym_bits_d;
      sym_valid_q <= sym_valid_d;
      i_acc_q     <= i_acc_d;
      q_acc_q     <= q_acc_d;
      sym_err_q   <= sym_err_d;
      sym_count_q <= sym_count_d;
    end
  end

  assign sym_bits  = sym_bits_q;
  assign sym_valid = sym_valid_q;
  assign i_acc     = i_acc_q;
  assign q_acc     = q_acc_q;
  assign sym_err   = sym_err_q;
  assign sym_count = sym_count_q;

endmodule

// File: tb/tb_qpsk_symbol_detector.sv
// Self-checking bench for qpsk_symbol_detector: scenario tasks drive samples,
// a list-of-samples correlation model predicts each symbol decision.
module tb_qpsk_symbol_detector;

  localparam int DATA_W   = 10;
  localparam int ACC_W    = 24;
  localparam int E_THRESH = 40000;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic signed [DATA_W-1:0] sample_in = '0;
  logic                     sample_valid = 1'b0;
  logic                     sync_clr = 1'b0;
  logic [1:0]               sym_bits;
  logic                     sym_valid;
  logic signed [ACC_W-1:0]  i_acc;
  logic signed [ACC_W-1:0]  q_acc;
  logic                     sym_err;
  logic [15:0]              sym_count;

  qpsk_symbol_detector #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .E_THRESH (E_THRESH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sync_clr     (sync_clr),
    .sym_bits     (sym_bits),
    .sym_valid    (sym_valid),
    .i_acc        (i_acc),
    .q_acc        (q_acc),
    .sym_err      (sym_err),
    .sym_count    (sym_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  typedef struct {
    int         cyc;
    logic [1:0] bits;
    int         i;
    int         q;
    logic       err;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  exp_t sb_e;
  int   acc_buf[$];
  int   exp_count = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_pulse = 0;
  int   cos_tab[16] = '{100, 92, 71, 38, 0, -38, -71, -92,
                        -100, -92, -71, -38, 0, 38, 71, 92};

  function automatic exp_t model_symbol(input int s[$], input int done_cyc, input int cnt);
    exp_t e;
    int   i = 0;
    int   q = 0;
    int   mag;
    foreach (s[k]) begin
      i += s[k] * cos_tab[k];
      q += s[k] * cos_tab[(k + 12) % 16];
    end
    mag    = (i < 0 ? -i : i) + (q < 0 ? -q : q);
    e.cyc  = done_cyc;
    e.bits = {(i >= 0), (q >= 0)};
    e.i    = i;
    e.q    = q;
    e.err  = (mag < E_THRESH);
    e.cnt  = cnt;
    return e;
  endfunction

  function automatic int wave(input logic [1:0] b, input int k, input int noise);
    int n;
    n = (noise == 0) ? 0 : int'($urandom_range(0, 2 * noise)) - noise;
    return (b[1] ? 1 : -1) * cos_tab[k] + (b[0] ? 1 : -1) * cos_tab[(k + 12) % 16] + n;
  endfunction

  function automatic void model_reset();
    acc_buf.delete();
    exp_q.delete();
    exp_count = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int s, input bit v, input bit clr);
    @(posedge clk);
    #1;
    sample_in    = s[DATA_W-1:0];
    sample_valid = v;
    sync_clr     = clr;
    if (clr) begin
      acc_buf.delete();
    end else if (v) begin
      acc_buf.push_back(s);
      if (acc_buf.size() == 16) begin
        exp_count = (exp_count + 1) % 65536;
        exp_q.push_back(model_symbol(acc_buf, cyc + 3, exp_count));
        acc_buf.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(int'($urandom_range(0, 1023)) - 512, 1'b0, 1'b0);
  endtask

  task automatic send_symbol(input logic [1:0] b, input int noise);
    for (int k = 0; k < 16; k++) drive(wave(b, k, noise), 1'b1, 1'b0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      idle(1);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    idle(4);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && sym_valid) begin
      n_pulse++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cyc=%0d bits=%b required no pulse", cyc, sym_bits);
      end else begin
        sb_e = exp_q.pop_front();
        if (cyc !== sb_e.cyc) begin
          n_fail++;
          $display("FAIL pulse_time: got cyc %0d required %0d", cyc, sb_e.cyc);
        end
        n_cmp++;
        if (sym_bits !== sb_e.bits) begin
          n_fail++;
          $display("FAIL sym_bits: got %b required %b", sym_bits, sb_e.bits);
        end
        n_cmp++;
        if (i_acc !== sb_e.i[ACC_W-1:0]) begin
          n_fail++;
          $display("FAIL i_acc: got %0d required %0d", i_acc, sb_e.i);
        end
        n_cmp++;
        if (q_acc !== sb_e.q[ACC_W-1:0]) begin
          n_fail++;
          $display("FAIL q_acc: got %0d required %0d", q_acc, sb_e.q);
        end
        n_cmp++;
        if (sym_err !== sb_e.err) begin
          n_fail++;
          $display("FAIL sym_err: got %b required %b", sym_err, sb_e.err);
        end
        n_cmp++;
        if (sym_count !== sb_e.cnt[15:0]) begin
          n_fail++;
          $display("FAIL sym_count: got %0d required %0d", sym_count, sb_e.cnt);
        end
        last_exp = sb_e;
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic check_zero_outputs(input string tag);
    n_cmp++;
    if ({sym_bits, sym_valid, i_acc, q_acc, sym_err, sym_count} !== '0) begin
      n_fail++;
      $display("FAIL %s: bits=%b valid=%b i=%0d q=%0d err=%b cnt=%0d required all 0",
               tag, sym_bits, sym_valid, i_acc, q_acc, sym_err, sym_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sample_valid = 1'b0;
    sync_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(2);
  endtask

  task automatic test_stream();
    for (int r = 0; r < 3; r++) send_symbol(2'b01, 0);
    wait_drain();
    n_cmp++;
    if (sym_count !== 16'd3) begin
      n_fail++;
      $display("FAIL stream_count: got %0d required 3", sym_count);
    end
    n_cmp++;
    if (i_acc !== -24'sd79796 || q_acc !== 24'sd79796) begin
      n_fail++;
      $display("FAIL stream_corr: got i=%0d q=%0d required -79796/79796", i_acc, q_acc);
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++) send_symbol(2'(b), 3);
    wait_drain();
    n_cmp++;
    if (sym_bits !== 2'b11 || i_acc !== last_exp.i[ACC_W-1:0]) begin
      n_fail++;
      $display("FAIL b2b_hold: got bits=%b i=%0d required 11 i=%0d", sym_bits, i_acc, last_exp.i);
    end
  endtask

  task automatic test_zero();
    for (int k = 0; k < 16; k++) drive(0, 1'b1, 1'b0);
    wait_drain();
    n_cmp++;
    if (sym_err !== 1'b1 || sym_bits !== 2'b11 || i_acc !== '0 || q_acc !== '0) begin
      n_fail++;
      $display("FAIL zero_symbol: got err=%b bits=%b i=%0d q=%0d required 1 11 0 0",
               sym_err, sym_bits, i_acc, q_acc);
    end
  endtask

  task automatic test_gaps();
    int p0 = n_pulse;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      drive(wave(2'b10, k, 4), 1'b1, 1'b0);
    end
    wait_drain();
    n_cmp++;
    if (n_pulse - p0 !== 1 || sym_bits !== 2'b10) begin
      n_fail++;
      $display("FAIL gaps: got pulses=%0d bits=%b required 1 10", n_pulse - p0, sym_bits);
    end
  endtask

  task automatic test_sync_clr();
    int p0 = n_pulse;
    for (int k = 0; k < 7; k++) drive(wave(2'b00, k, 0), 1'b1, 1'b0);
    drive(77, 1'b1, 1'b1);
    idle(3);
    n_cmp++;
    if (i_acc !== last_exp.i[ACC_W-1:0] || sym_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL sync_hold: got i=%0d cnt=%0d required i=%0d cnt=%0d",
               i_acc, sym_count, last_exp.i, exp_count);
    end
    send_symbol(2'b11, 2);
    wait_drain();
    n_cmp++;
    if (n_pulse - p0 !== 1 || sym_bits !== 2'b11) begin
      n_fail++;
      $display("FAIL sync_clr: got pulses=%0d bits=%b required 1 11", n_pulse - p0, sym_bits);
    end
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 9; k++) drive(wave(2'b10, k, 0), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_zero_outputs("mid_reset_during");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("mid_reset_after");
    send_symbol(2'b10, 1);
    wait_drain();
    n_cmp++;
    if (sym_count !== 16'd1 || sym_bits !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_reset_count: got cnt=%0d bits=%b required 1 10", sym_count, sym_bits);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 16; k++)
        drive(int'($urandom_range(0, 1022)) - 511, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) drive(int'($urandom_range(0, 40)) - 20, 1'b1, 1'b0);
    wait_drain();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_zero();
    test_gaps();
    test_sync_clr();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
